sobel_window_gen: RTL and testbench
===================================

Name: sobel_window_gen

Overview:
- Streaming 3x3 neighbourhood generator between the SPI pixel receive path and the Sobel kernel inside the gray/Sobel pipeline.
- Accepts one grayscale pixel per px_rdy_i strobe in raster order.
- Holds two previous image rows in line delay buffers.
- Emits a full 3x3 window with a one-cycle strobe for every interior pixel position. No border padding.

Parameters:
- IMG_WIDTH, 8, pixels per row; must be >= 3.
- IMG_HEIGHT, 8, rows per frame; must be >= 3.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- reset_i  in  1  asynchronous, active-high reset; clears all state.
- start_i  in  1  synchronous frame start; arms or restarts a frame.
- px_rdy_i  in  1  single-cycle strobe; in_pixel_i is valid this cycle.
- in_pixel_i  in  MAX_PIXEL_BITS  grayscale pixel.
- window_o  out  9*MAX_PIXEL_BITS  3x3 window; element k = 3*r + c at [k*MAX_PIXEL_BITS +: MAX_PIXEL_BITS]; r=0 is the oldest row, c=0 is the oldest column.
- window_rdy_o  out  1  single-cycle strobe; window_o is valid.
- frame_done_o  out  1  single-cycle strobe after the last pixel of a frame.
- busy_o  out  1  high while in FILL or STREAM.

Behaviour:
- Interface: one clock (clk_i). Reset (reset_i) is asynchronous and active-high.
- Reset values: window_o=0, window_rdy_o=0, frame_done_o=0, busy_o=0, state=IDLE, col/row counters=0, line buffers=0.
- States:
  - IDLE: px_rdy_i is ignored. start_i -> FILL.
  - FILL: rows 0..1 are being written. Each accepted pixel shifts the line buffers and the window. At the end of row 1 (col=IMG_WIDTH-1, row=1) -> STREAM.
  - STREAM: rows 2..IMG_HEIGHT-1. At the last pixel (col=IMG_WIDTH-1, row=IMG_HEIGHT-1): frame_done_o=1 next cycle, then -> IDLE.
- Counters: col wraps IMG_WIDTH-1 -> 0 and increments row. Counter widths come from $clog2 of the parameter.
- Delay lines: line buffer A delays the pixel stream by IMG_WIDTH accepted pixels. Buffer B delays A's output by a further IMG_WIDTH. Shift only on accepted px_rdy_i.
- Window: three 3-deep column shift registers (B out, A out, in_pixel_i) shift on each accepted pixel.
- Window output condition: row>=2 and col>=2 for the accepted pixel. window_rdy_o is registered, asserted the cycle after the px_rdy_i, with window_o updated in that same cycle.
- Window hold: window_o holds its value between strobes.
- Window count: exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) strobes per frame.
- No window straddles a row wrap. Cols 0..1 of each row only refill the window registers.
- Rate and gaps: at most one pixel per cycle; arbitrary idle gaps between px_rdy_i are allowed. There is no backpressure.
- start_i in FILL or STREAM:
  - Counters clear and the state goes to FILL.
  - Line buffer contents are not cleared; they are overwritten before use.
  - Any pending output strobe for that cycle is suppressed.
- start_i and px_rdy_i in the same cycle: start wins; the pixel is dropped.
- Last pixel: window_rdy_o and frame_done_o assert in the same cycle.
- Reset mid-frame: immediate return to reset values.

Optional Feature:
- Macro: SOBEL_WIN_FRAME_ERR_EN.
- When defined:
  - Adds output frame_err_o (1 bit), a sticky flag.
  - Set by start_i while in FILL or STREAM (an aborted frame).
  - Set by px_rdy_i in IDLE (a stray pixel).
  - Cleared only by reset_i, or by start_i while in IDLE.
- When undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: MAX_PIXEL_BITS (8) from the existing parameters header.
- Shared package additions:
  - window state enum typedef (IDLE, FILL, STREAM).
  - window element index constants (WIN_TL=0 ... WIN_BR=8).
- One sub-module: sobel_line_delay.
  - Parameterised DEPTH and WIDTH, enable-gated shift-register delay line.
  - Instantiated twice, for buffers A and B.

Test Plan:
- Basic: IMG_WIDTH=4, IMG_HEIGHT=4, start_i, then pixels 0..15 back-to-back -> 4 strobes:
  - {0,1,2,4,5,6,8,9,10}
  - {1,2,3,5,6,7,9,10,11}
  - {4,5,6,8,9,10,12,13,14}
  - {5,6,7,9,10,11,13,14,15}
  - Each strobe is one cycle after pixels 10, 11, 14, 15.
  - frame_done_o is coincident with the last strobe.
  - busy_o returns to 0.
- Gaps: same frame with 0-3 random idle cycles between pixels -> identical window values; each strobe is exactly one cycle after its pixel.
- Restart: start_i after pixel 7, then a new frame 100..115 -> no strobes from the old frame; windows built solely from 100..115, first {100,101,102,104,105,106,108,109,110}. With SOBEL_WIN_FRAME_ERR_EN, frame_err_o=1.
- Idle pixels: px_rdy_i in IDLE, and start_i coincident with pixel 0 -> those pixels are ignored; the frame then aligns to the next pixel.
- Reset mid-frame: reset_i asserted at pixel 12 -> all outputs are 0 in the same cycle; the next start_i frame produces the correct 4 windows.
- Size sweep: IMG_WIDTH=8, IMG_HEIGHT=8, random pixels vs. a reference model -> 36 strobes, all windows match.

Source files
------------

// File: rtl/sobel_window_gen_pkg.sv
// Shared types and constants for the Sobel 3x3 window generator.
package sobel_window_gen_pkg;

    localparam int unsigned MAX_PIXEL_BITS = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } win_state_t;

    // Window element index k = 3*row + col (row 0 oldest, col 0 oldest)
    localparam int unsigned WIN_TL = 0;
    localparam int unsigned WIN_TC = 1;
    localparam int unsigned WIN_TR = 2;
    localparam int unsigned WIN_ML = 3;
    localparam int unsigned WIN_MC = 4;
    localparam int unsigned WIN_MR = 5;
    localparam int unsigned WIN_BL = 6;
    localparam int unsigned WIN_BC = 7;
    localparam int unsigned WIN_BR = 8;

endpackage

// File: rtl/sobel_line_delay.sv
// Enable-gated shift-register delay line: o_dout is the sample pushed DEPTH enables ago.
module sobel_line_delay #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    logic [WIDTH-1:0] r_taps [DEPTH];

    // Shift one position per enabled cycle
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_taps[i] <= '0;
            end
        end else if (i_en) begin
            r_taps[0] <= i_din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_taps[i] <= r_taps[i-1];
            end
        end
    end

    assign o_dout = r_taps[DEPTH-1];

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator for the Sobel kernel; interior pixels only.
// Optional sticky frame_err_o output enabled by defining SOBEL_WIN_FRAME_ERR_EN.
module sobel_window_gen
    import sobel_window_gen_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 8,
    parameter int unsigned IMG_HEIGHT = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        start_i,
    input  logic                        px_rdy_i,
    input  logic [MAX_PIXEL_BITS-1:0]   in_pixel_i,
    output logic [9*MAX_PIXEL_BITS-1:0] window_o,
    output logic                        window_rdy_o,
    output logic                        frame_done_o,
`ifdef SOBEL_WIN_FRAME_ERR_EN
    output logic                        frame_err_o,
`endif
    output logic                        busy_o
);

    localparam int unsigned PW    = MAX_PIXEL_BITS;
    localparam int unsigned COL_W = $clog2(IMG_WIDTH);
    localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);

    win_state_t       r_state;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [PW-1:0]    r_win [3][3];

    logic [PW-1:0]    w_a_out;
    logic [PW-1:0]    w_b_out;
    logic [PW-1:0]    w_new [3];
    logic [9*PW-1:0]  w_win_next;
    logic             w_accept;
    logic             w_col_last;
    logic             w_row_last;
    logic             w_interior;

    assign w_accept   = px_rdy_i && !start_i && (r_state != IDLE);
    assign w_col_last = (r_col == COL_W'(IMG_WIDTH - 1));
    assign w_row_last = (r_row == ROW_W'(IMG_HEIGHT - 1));
    assign w_interior = (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));

    sobel_line_delay #(.DEPTH(IMG_WIDTH), .WIDTH(PW)) u_line_a (
        .i_clk   (clk_i),
        .i_reset (reset_i),
        .i_en    (w_accept),
        .i_din   (in_pixel_i),
        .o_dout  (w_a_out)
    );

    sobel_line_delay #(.DEPTH(IMG_WIDTH), .WIDTH(PW)) u_line_b (
        .i_clk   (clk_i),
        .i_reset (reset_i),
        .i_en    (w_accept),
        .i_din   (w_a_out),
        .o_dout  (w_b_out)
    );

    // Window contents after the shift caused by the current pixel
    always_comb begin
        w_new[0]   = w_b_out;
        w_new[1]   = w_a_out;
        w_new[2]   = in_pixel_i;
        w_win_next = '0;
        w_win_next[WIN_TL*PW +: PW] = r_win[0][1];
        w_win_next[WIN_TC*PW +: PW] = r_win[0][2];
        w_win_next[WIN_TR*PW +: PW] = w_new[0];
        w_win_next[WIN_ML*PW +: PW] = r_win[1][1];
        w_win_next[WIN_MC*PW +: PW] = r_win[1][2];
        w_win_next[WIN_MR*PW +: PW] = w_new[1];
        w_win_next[WIN_BL*PW +: PW] = r_win[2][1];
        w_win_next[WIN_BC*PW +: PW] = r_win[2][2];
        w_win_next[WIN_BR*PW +: PW] = w_new[2];
    end

    // Column shift registers: one per window row, oldest column at index 0
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= r_win[r][2];
                r_win[r][2] <= w_new[r];
            end
        end
    end

    // Frame FSM, raster counters and registered output strobes
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state      <= IDLE;
            r_col        <= '0;
            r_row        <= '0;
            window_o     <= '0;
            window_rdy_o <= 1'b0;
            frame_done_o <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            window_rdy_o <= 1'b0;
            frame_done_o <= 1'b0;
            if (start_i) begin
                r_state <= FILL;
                r_col   <= '0;
                r_row   <= '0;
                busy_o  <= 1'b1;
            end else if (w_accept) begin
                if (w_interior) begin
                    window_o     <= w_win_next;
                    window_rdy_o <= 1'b1;
                end
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= r_row + ROW_W'(1);
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
                case (r_state)
                    FILL: begin
                        if (w_col_last && (r_row == ROW_W'(1))) begin
                            r_state <= STREAM;
                        end
                    end
                    STREAM: begin
                        if (w_col_last && w_row_last) begin
                            r_state      <= IDLE;
                            r_col        <= '0;
                            r_row        <= '0;
                            frame_done_o <= 1'b1;
                            busy_o       <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef SOBEL_WIN_FRAME_ERR_EN
    // Sticky error: aborted frame or stray pixel; cleared by a clean start
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            frame_err_o <= 1'b0;
        end else if (start_i) begin
            frame_err_o <= (r_state != IDLE);
        end else if (px_rdy_i && (r_state == IDLE)) begin
            frame_err_o <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen: 4x4 instance for directed frames, 8x8 for a random sweep.
module tb_sobel_window_gen;
    import sobel_window_gen_pkg::*;

    localparam int unsigned PW = MAX_PIXEL_BITS;
    localparam int unsigned WW = 9 * PW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          st4, px4, st8, px8;
    logic [PW-1:0] pix4, pix8;
    logic [WW-1:0] win4, win8;
    logic          rdy4, done4, busy4, rdy8, done8, busy8;
`ifdef SOBEL_WIN_FRAME_ERR_EN
    logic          err4, err8;
`endif

    sobel_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
        .clk_i        (clk),
        .reset_i      (rst),
        .start_i      (st4),
        .px_rdy_i     (px4),
        .in_pixel_i   (pix4),
        .window_o     (win4),
        .window_rdy_o (rdy4),
        .frame_done_o (done4),
`ifdef SOBEL_WIN_FRAME_ERR_EN
        .frame_err_o  (err4),
`endif
        .busy_o       (busy4)
    );

    sobel_window_gen #(.IMG_WIDTH(8), .IMG_HEIGHT(8)) dut8 (
        .clk_i        (clk),
        .reset_i      (rst),
        .start_i      (st8),
        .px_rdy_i     (px8),
        .in_pixel_i   (pix8),
        .window_o     (win8),
        .window_rdy_o (rdy8),
        .frame_done_o (done8),
`ifdef SOBEL_WIN_FRAME_ERR_EN
        .frame_err_o  (err8),
`endif
        .busy_o       (busy8)
    );

    typedef struct {
        logic [WW-1:0] win;
        logic          done;
        int            cyc;
    } exp_t;

    exp_t          q4[$];
    exp_t          q8[$];
    exp_t          mon_e;
    int            cyc   = 0;
    int            total = 0;
    int            bad   = 0;
    int            cnt8  = 0;
    logic [PW-1:0] frm [64];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Hand-derived 4x4 windows: first window offsets, +1 per column step, +4 per row step
    function automatic logic [WW-1:0] hand_win(input int h, input int base);
        int            o [9];
        logic [WW-1:0] r;
        o = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        r = '0;
        for (int k = 0; k < 9; k++) begin
            r[k*PW +: PW] = PW'(base + o[k] + (h % 2) + 4 * (h / 2));
        end
        return r;
    endfunction

    // Reference window read straight out of the frame image
    function automatic logic [WW-1:0] model(input int i, input int w);
        int            r;
        int            c;
        logic [WW-1:0] m;
        r = i / w;
        c = i % w;
        m = '0;
        for (int rr = 0; rr < 3; rr++) begin
            for (int cc = 0; cc < 3; cc++) begin
                m[(3*rr+cc)*PW +: PW] = frm[(r - 2 + rr) * w + (c - 2 + cc)];
            end
        end
        return m;
    endfunction

    // Monitor: pop and compare on every strobe
    always @(negedge clk) begin
        if (rdy4) begin
            if (q4.size() == 0) begin
                check("extra_strobe4", WW'(rdy4), WW'(0));
            end else begin
                mon_e = q4.pop_front();
                check("win4", win4, mon_e.win);
                check("done4", WW'(done4), WW'(mon_e.done));
                check("cyc4", WW'(cyc), WW'(mon_e.cyc));
            end
        end else if (done4) begin
            check("done_alone4", WW'(done4), WW'(0));
        end
        if (rdy8) begin
            cnt8++;
            if (q8.size() == 0) begin
                check("extra_strobe8", WW'(rdy8), WW'(0));
            end else begin
                mon_e = q8.pop_front();
                check("win8", win8, mon_e.win);
                check("done8", WW'(done8), WW'(mon_e.done));
                check("cyc8", WW'(cyc), WW'(mon_e.cyc));
            end
        end else if (done8) begin
            check("done_alone8", WW'(done8), WW'(0));
        end
    end

    // One input cycle, driven just after the active edge
    task automatic drv(input bit big, input logic st, input logic px, input logic [PW-1:0] p);
        @(posedge clk);
        #1;
        if (big) begin
            st8 = st; px8 = px; pix8 = p;
        end else begin
            st4 = st; px4 = px; pix4 = p;
        end
    endtask

    // Send frm[0..n_send-1]; hand_base < 0 selects the image model for expectations
    task automatic send_frame(input bit big, input int max_gap, input int hand_base, input int n_send);
        int   w;
        int   hidx;
        exp_t e;
        w    = big ? 8 : 4;
        hidx = 0;
        for (int i = 0; i < n_send; i++) begin
            drv(big, 1'b0, 1'b1, frm[i]);
            if ((i / w >= 2) && (i % w >= 2)) begin
                if (hand_base >= 0) begin
                    e.win = hand_win(hidx, hand_base);
                    hidx++;
                end else begin
                    e.win = model(i, w);
                end
                e.done = (i == w * w - 1);
                e.cyc  = cyc + 1;
                if (big) q8.push_back(e);
                else     q4.push_back(e);
            end
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) drv(big, 1'b0, 1'b0, '0);
        end
        drv(big, 1'b0, 1'b0, '0);
    endtask

    task automatic start4();
        drv(1'b0, 1'b1, 1'b0, '0);
        drv(1'b0, 1'b0, 1'b0, '0);
        check("busy4_after_start", WW'(busy4), WW'(1));
    endtask

    task automatic tail4(input string name);
        repeat (3) drv(1'b0, 1'b0, 1'b0, '0);
        check({name, "_busy4_idle"}, WW'(busy4), WW'(0));
        check({name, "_q4_drained"}, WW'(q4.size()), WW'(0));
    endtask

    initial begin
        rst = 1'b1;
        st4 = 1'b0; px4 = 1'b0; pix4 = '0;
        st8 = 1'b0; px8 = 1'b0; pix8 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_win4", win4, WW'(0));
        check("rst_rdy4", WW'(rdy4), WW'(0));
        check("rst_done4", WW'(done4), WW'(0));
        check("rst_busy4", WW'(busy4), WW'(0));
        check("rst_busy8", WW'(busy8), WW'(0));
        rst = 1'b0;

        // Basic back-to-back 4x4 frame
        for (int i = 0; i < 16; i++) frm[i] = PW'(i);
        start4();
        send_frame(1'b0, 0, 0, 16);
        tail4("basic");

        // Same frame with random idle gaps
        start4();
        send_frame(1'b0, 3, 0, 16);
        tail4("gaps");

        // Restart after pixel 7, then a fresh frame 100..115
        start4();
        for (int i = 0; i < 8; i++) drv(1'b0, 1'b0, 1'b1, PW'(i));
        drv(1'b0, 1'b1, 1'b0, '0);
        drv(1'b0, 1'b0, 1'b0, '0);
`ifdef SOBEL_WIN_FRAME_ERR_EN
        check("err4_abort", WW'(err4), WW'(1));
`endif
        for (int i = 0; i < 16; i++) frm[i] = PW'(100 + i);
        send_frame(1'b0, 0, 100, 16);
        tail4("restart");

        // Stray pixels in IDLE, then start coincident with a dropped pixel
        drv(1'b0, 1'b0, 1'b1, PW'(200));
        drv(1'b0, 1'b0, 1'b1, PW'(201));
        check("stray_busy4", WW'(busy4), WW'(0));
        check("stray_rdy4", WW'(rdy4), WW'(0));
`ifdef SOBEL_WIN_FRAME_ERR_EN
        check("err4_stray", WW'(err4), WW'(1));
`endif
        drv(1'b0, 1'b1, 1'b1, PW'(222));
        drv(1'b0, 1'b0, 1'b0, '0);
`ifdef SOBEL_WIN_FRAME_ERR_EN
        check("err4_cleared", WW'(err4), WW'(0));
`endif
        for (int i = 0; i < 16; i++) frm[i] = PW'(50 + i);
        send_frame(1'b0, 0, 50, 16);
        tail4("idlepix");

        // Asynchronous reset right after pixel 12
        for (int i = 0; i < 16; i++) frm[i] = PW'(i);
        start4();
        send_frame(1'b0, 0, 0, 12);
        drv(1'b0, 1'b0, 1'b1, PW'(12));
        drv(1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_win4", win4, WW'(0));
        check("midrst_rdy4", WW'(rdy4), WW'(0));
        check("midrst_done4", WW'(done4), WW'(0));
        check("midrst_busy4", WW'(busy4), WW'(0));
        check("midrst_q4", WW'(q4.size()), WW'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        start4();
        send_frame(1'b0, 0, 0, 16);
        tail4("after_rst");

        // 8x8 random sweep against the image model
        for (int i = 0; i < 64; i++) frm[i] = PW'($urandom_range(0, 255));
        drv(1'b1, 1'b1, 1'b0, '0);
        drv(1'b1, 1'b0, 1'b0, '0);
        check("busy8_after_start", WW'(busy8), WW'(1));
        send_frame(1'b1, 0, -1, 64);
        repeat (3) drv(1'b1, 1'b0, 1'b0, '0);
        check("sweep_busy8_idle", WW'(busy8), WW'(0));
        check("sweep_q8_drained", WW'(q8.size()), WW'(0));
        check("sweep_strobe_count", WW'(cnt8), WW'(36));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
